scene_byte_unpacker: RTL and testbench

SCENE_BYTE_UNPACKER -- requirements
Module: scene_byte_unpacker

---
 rtl/scene_byte_unpacker.sv | 117 +++++++++++
 tb/tb_scene_byte_unpacker.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/scene_byte_unpacker.sv
// Byte-to-bit unpacker for scene loading: accepts packed voxel bytes and emits
// one addressed occupancy bit per handshake until the whole address space is covered.
module scene_byte_unpacker #(
  parameter int unsigned ADDR_BITS = 15,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_mode,
  input  logic                 byte_valid,
  output logic                 byte_ready,
  input  logic [7:0]           byte_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ADDR_BITS-1:0] out_addr,
  output logic                 out_data,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e               state;
  state_e               state_nxt;
  logic [7:0]           shreg;
  logic [2:0]           idx;
  logic [ADDR_BITS-1:0] addr;

  logic last_addr;
  logic last_bit;
  logic out_hs;
  logic byte_hs;

  assign last_addr = (addr == {ADDR_BITS{1'b1}});
  assign last_bit  = (idx == 3'd7);
  assign out_hs    = out_valid && out_ready;
  assign byte_hs   = byte_valid && byte_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; dropping load_mode always returns to EMPTY
  always_comb begin
    state_nxt = state;
    if (!load_mode) begin
      state_nxt = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: if (byte_hs) state_nxt = ST_SHIFT;
        ST_SHIFT: begin
          if (out_hs && last_bit) begin
            if (last_addr)    state_nxt = ST_DONE;
            else if (byte_hs) state_nxt = ST_SHIFT;
            else              state_nxt = ST_EMPTY;
          end
        end
        ST_DONE:  state_nxt = ST_DONE;
        default:  state_nxt = ST_EMPTY;
      endcase
    end
  end

  // Outputs decoded from registered state; byte_ready may reload on the final bit
  always_comb begin
    out_valid  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    byte_ready = 1'b0;
    out_addr   = addr;
    out_data   = LSB_FIRST ? shreg[idx] : shreg[3'd7 - idx];
    case (state)
      ST_EMPTY: byte_ready = load_mode;
      ST_SHIFT: begin
        out_valid  = 1'b1;
        busy       = 1'b1;
        byte_ready = load_mode && last_bit && out_ready && !last_addr;
      end
      ST_DONE:  done = 1'b1;
      default:  ;
    endcase
  end

  // Shift register, bit index and address counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= 8'h00;
      idx   <= 3'd0;
      addr  <= '0;
    end else if (!load_mode) begin
      shreg <= 8'h00;
      idx   <= 3'd0;
      addr  <= '0;
    end else begin
      if (byte_hs) begin
        shreg <= byte_data;
      end
      if (state == ST_EMPTY && byte_hs) begin
        idx <= 3'd0;
      end
      if (out_hs) begin
        addr <= addr + ADDR_BITS'(1);
        idx  <= idx + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_scene_byte_unpacker.sv
// Bench for scene_byte_unpacker: three instances (wide LSB-first, 3-bit address,
// MSB-first) checked each cycle against a queue-of-bits reference model.
module tb_scene_byte_unpacker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [2:0] lm;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       out_ready;

  logic [2:0]  br, ov, od, bz, dn;
  logic [14:0] oa0;
  logic [2:0]  oa1;
  logic [3:0]  oa2;

  scene_byte_unpacker #(.ADDR_BITS(15), .LSB_FIRST(1'b1)) u_a15 (
    .clk(clk), .rst_n(rst_n), .load_mode(lm[0]), .byte_valid(byte_valid),
    .byte_ready(br[0]), .byte_data(byte_data), .out_valid(ov[0]), .out_ready(out_ready),
    .out_addr(oa0), .out_data(od[0]), .busy(bz[0]), .done(dn[0]));

  scene_byte_unpacker #(.ADDR_BITS(3), .LSB_FIRST(1'b1)) u_a3 (
    .clk(clk), .rst_n(rst_n), .load_mode(lm[1]), .byte_valid(byte_valid),
    .byte_ready(br[1]), .byte_data(byte_data), .out_valid(ov[1]), .out_ready(out_ready),
    .out_addr(oa1), .out_data(od[1]), .busy(bz[1]), .done(dn[1]));

  scene_byte_unpacker #(.ADDR_BITS(4), .LSB_FIRST(1'b0)) u_a4m (
    .clk(clk), .rst_n(rst_n), .load_mode(lm[2]), .byte_valid(byte_valid),
    .byte_ready(br[2]), .byte_data(byte_data), .out_valid(ov[2]), .out_ready(out_ready),
    .out_addr(oa2), .out_data(od[2]), .busy(bz[2]), .done(dn[2]));

  int          sel;
  logic [31:0] obs_addr;
  always_comb begin
    case (sel)
      1:       obs_addr = 32'(oa1);
      2:       obs_addr = 32'(oa2);
      default: obs_addr = 32'(oa0);
    endcase
  end

  int vectors = 0;
  int miscompares = 0;

  // Reference model: pending emission bits, next address, done flag
  bit         q[$];
  logic [7:0] pend[$];
  int         exp_addr;
  bit         exp_done;
  int         abits;
  bit         lsb;

  function automatic int max_addr();
    return (1 << abits) - 1;
  endfunction

  function automatic bit m_byte_ready();
    return lm[sel] && ((q.size() == 0 && !exp_done) ||
                       (q.size() == 1 && out_ready && exp_addr != max_addr()));
  endfunction

  task automatic model_reset();
    q.delete();
    exp_addr = 0;
    exp_done = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s sel=%0d observed=%0h expected=%0h", tag, sel, o, e);
    end
  endtask

  task automatic compare();
    chk("out_valid", 32'(ov[sel]), 32'(q.size() > 0));
    chk("busy", 32'(bz[sel]), 32'(q.size() > 0));
    chk("done", 32'(dn[sel]), 32'(exp_done));
    chk("byte_ready", 32'(br[sel]), 32'(m_byte_ready()));
    chk("out_addr", obs_addr, 32'(exp_addr));
    if (q.size() > 0) chk("out_data", 32'(od[sel]), 32'(q[0]));
  endtask

  task automatic cycle(input bit ordy, input bit bven);
    bit ohs, bhs;
    logic [7:0] b;
    out_ready  = ordy;
    byte_valid = bven && (pend.size() > 0);
    byte_data  = (pend.size() > 0) ? pend[0] : 8'h00;
    @(negedge clk);
    compare();
    ohs = (q.size() > 0) && ordy;
    bhs = byte_valid && m_byte_ready();
    @(posedge clk);
    if (!lm[sel]) begin
      model_reset();
    end else begin
      if (ohs) begin
        void'(q.pop_front());
        if (exp_addr == max_addr()) begin
          exp_done = 1'b1;
          exp_addr = 0;
        end else begin
          exp_addr++;
        end
      end
      if (bhs) begin
        b = pend.pop_front();
        for (int i = 0; i < 8; i++) q.push_back(lsb ? b[i] : b[7-i]);
      end
    end
    #1;
  endtask

  task automatic drain(input int budget, input bit rnd);
    int n = 0;
    while ((pend.size() > 0 || q.size() > 0) && n < budget) begin
      cycle(rnd ? ($urandom_range(0, 3) != 0) : 1'b1, rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      n++;
    end
    chk("drain_budget", 32'(q.size() + pend.size()), 32'd0);
  endtask

  initial begin
    sel = 0; abits = 15; lsb = 1'b1;
    model_reset();
    rst_n = 1'b0; lm = 3'b000; byte_valid = 1'b0; byte_data = 8'h00; out_ready = 1'b0;
    @(posedge clk); #1;
    compare();
    lm = 3'b001; #1;
    compare();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Back-to-back 0xA5, 0x3C at full throughput
    pend.push_back(8'hA5); pend.push_back(8'h3C);
    repeat (17) cycle(1'b1, 1'b1);
    drain(50, 1'b0);

    // Backpressure held for 5 cycles at index 3
    pend.push_back(8'($urandom));
    repeat (4) cycle(1'b1, 1'b1);
    repeat (5) cycle(1'b0, 1'b1);
    drain(50, 1'b0);

    // Random traffic
    repeat (30) pend.push_back(8'($urandom));
    drain(2000, 1'b1);

    // Flush at index 4, then new session from address 0
    pend.push_back(8'hC3);
    repeat (5) cycle(1'b1, 1'b1);
    lm = 3'b000;
    cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b1);
    lm = 3'b001;
    pend.push_back(8'h5A);
    drain(50, 1'b0);

    // Async reset pulse in the middle of a byte
    pend.push_back(8'h96);
    repeat (3) cycle(1'b1, 1'b1);
    byte_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 model_reset();
    compare();
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    pend.push_back(8'h0F);
    drain(50, 1'b0);

    // ADDR_BITS=3: completion and ignored bytes while done
    lm = 3'b000;
    cycle(1'b1, 1'b0);
    sel = 1; abits = 3; lsb = 1'b1;
    model_reset();
    lm = 3'b010;
    pend.push_back(8'hFF);
    repeat (9) cycle(1'b1, 1'b1);
    pend.push_back(8'h55);
    repeat (4) cycle(1'b1, 1'b1);
    pend.delete();
    lm = 3'b000;
    cycle(1'b1, 1'b0);
    lm = 3'b010;
    cycle(1'b1, 1'b0);
    pend.push_back(8'h6E);
    drain(50, 1'b1);

    // MSB-first ordering through to completion
    lm = 3'b000;
    cycle(1'b1, 1'b0);
    sel = 2; abits = 4; lsb = 1'b0;
    model_reset();
    lm = 3'b100;
    pend.push_back(8'h80);
    pend.push_back(8'($urandom));
    drain(200, 1'b1);
    pend.push_back(8'hFF);
    repeat (3) cycle(1'b1, 1'b1);
    pend.delete();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
